// File: rtl/owr_arbiter.sv
// Two-requester round-robin arbiter in front of a single one-wire controller.
// The owner issues commands one at a time; completion data and pulses go back
// only to the owner. A watchdog frees the bus from idle owners and from
// commands the controller never completes.
module owr_arbiter #(
  parameter int IDLE_TO = 4096,
  parameter int CMD_TO  = 2**24,
  parameter int CW      = 24
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_req,
  input  logic [1:0]  i_en,
  input  logic [5:0]  i_cmd0,
  input  logic [5:0]  i_cmd1,
  output logic [1:0]  o_gnt,
  output logic [1:0]  o_irq,
  output logic [1:0]  o_timeout,
  output logic        o_detect,
  output logic [15:0] o_data,
  output logic [5:0]  o_command,
  output logic        o_enable,
  input  logic        i_busy,
  input  logic        i_irq,
  input  logic        i_detect,
  input  logic [15:0] i_data
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ISSUE, S_WAIT} state_t;

  // Limits are compared against the count of completed cycles in the state,
  // so the last legal value is TO-1 (CMD_TO = 2**CW still fits).
  localparam logic [CW-1:0] IDLE_LIM = CW'(IDLE_TO - 1);
  localparam logic [CW-1:0] CMD_LIM  = CW'(CMD_TO - 1);

  state_t        state_q;
  logic          owner_q;   // index of current owner, valid while o_gnt != 0
  logic          rr_q;      // requester that wins the next tie
  logic [CW-1:0] wd_q, wd_d;
  logic [1:0]    gnt_q, irq_q, to_q;
  logic          en_q, det_q;
  logic [5:0]    cmd_q;
  logic [15:0]   data_q;

  logic          winner_d;
  logic          own_req, own_en;
  logic [5:0]    own_cmd;
  logic [1:0]    own_oh;

  // Owner-relative views of the request side and the arbitration winner.
  always_comb begin
    winner_d = (i_req == 2'b11) ? rr_q : i_req[1];
    wd_d     = wd_q + 1'b1;
    own_req  = i_req[owner_q];
    own_en   = i_en[owner_q];
    own_cmd  = owner_q ? i_cmd1 : i_cmd0;
    own_oh   = owner_q ? 2'b10 : 2'b01;
  end

  // Arbitration FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      wd_q    <= '0;
      gnt_q   <= 2'b00;
      irq_q   <= 2'b00;
      to_q    <= 2'b00;
      en_q    <= 1'b0;
      cmd_q   <= 6'd0;
      det_q   <= 1'b0;
      data_q  <= 16'd0;
    end else begin
      irq_q <= 2'b00;
      to_q  <= 2'b00;
      en_q  <= 1'b0;
      cmd_q <= 6'd0;
      wd_q  <= wd_d;
      case (state_q)
        S_IDLE: begin
          wd_q <= '0;
          if (|i_req) begin
            owner_q <= winner_d;
            rr_q    <= ~winner_d;
            gnt_q   <= winner_d ? 2'b10 : 2'b01;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!own_req) begin
            gnt_q   <= 2'b00;
            wd_q    <= '0;
            state_q <= S_IDLE;
          end else if (own_en && !i_busy) begin
            en_q    <= 1'b1;
            cmd_q   <= own_cmd;
            wd_q    <= '0;
            state_q <= S_ISSUE;
          end else if (wd_q == IDLE_LIM) begin
            to_q    <= own_oh;
            gnt_q   <= 2'b00;
            wd_q    <= '0;
            state_q <= S_IDLE;
          end
        end
        S_ISSUE: begin
          wd_q    <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // Completion or command timeout both return to GRANT, or release
          // if the owner already dropped its request while waiting.
          if (i_irq || wd_q == CMD_LIM) begin
            if (i_irq) begin
              det_q  <= i_detect;
              data_q <= i_data;
              irq_q  <= own_oh;
            end else begin
              to_q   <= own_oh;
            end
            wd_q <= '0;
            if (own_req) begin
              state_q <= S_GRANT;
            end else begin
              gnt_q   <= 2'b00;
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_gnt     = gnt_q;
  assign o_irq     = irq_q;
  assign o_timeout = to_q;
  assign o_enable  = en_q;
  assign o_command = cmd_q;
  assign o_detect  = det_q;
  assign o_data    = data_q;

endmodule
